apb_bus_arbiter: RTL and testbench
==================================

// Module: apb_bus_arbiter
// PURPOSE
// - APB master sharing one APB bus among N requesters (DMA, I2C ctrl, CPU port).
// - Round-robin arbitration; each winner's command becomes one APB SETUP/ACCESS transfer.
// - Drives sel as a 2-bit slave id (0 = no slave); waits on the slave's ready.
// - Returns read data and completion to the winning requester.
// PARAMETERS
// - N_REQ          default 3   number of requesters, 2..8
// - AW             default 8   APB address width
// - DW             default 8   APB data width
// - TIMEOUT_CYCLES default 16  ACCESS-phase cycle limit (APB_TIMEOUT_EN only), >=1
// PORTS
// - clk         in   1         single clock, all logic on posedge
// - reset       in   1         synchronous, active-high
// - req         in   N_REQ     per-requester request; held until own gnt
// - req_write   in   N_REQ     1=write 0=read
// - req_sel     in   2*N_REQ   target slave id 1..3 per requester; 0 illegal
// - req_addr    in   N_REQ*AW  per-requester address
// - req_wdata   in   N_REQ*DW  per-requester write data
// - gnt         out  N_REQ     one-hot 1-cycle pulse: command captured
// - done        out  N_REQ     one-hot 1-cycle pulse: transfer finished
// - rsp_rdata   out  DW        read data, valid in done cycle (0 for writes/errors)
// - rsp_err     out  1         error flag, valid in done cycle
// - apb_sel     out  2         slave id, 0 when bus idle
// - apb_write   out  1         transfer direction
// - apb_enable  out  1         high in ACCESS phase
// - apb_addr    out  AW        transfer address
// - apb_wdata   out  DW        write data
// - apb_rdata   in   DW        read data from slave
// - apb_ready   in   1         slave ready, sampled only in ACCESS
// BEHAVIOUR
// - Reset: state IDLE, rr_ptr=0, all outputs 0, counter 0.
// - Reset mid-transfer: transfer dropped; no done; bus idle next cycle.
// - FSM IDLE -> SETUP -> ACCESS -> IDLE. All outputs are registered.
// - IDLE, any req=1: winner = first set req scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
//   - Latch its write/sel/addr/wdata.
//   - Next cycle: gnt[winner]=1, state SETUP, apb_sel=id, apb_enable=0.
// - SETUP: exactly one cycle -> ACCESS, apb_enable=1. addr/wdata/write/sel stable.
// - ACCESS: stay until apb_ready=1, then next cycle:
//   - done[winner]=1; rsp_rdata=apb_rdata if read; rsp_err=0.
//   - apb_sel=0, apb_enable=0, state IDLE.
// - rr_ptr = (winner+1) mod N_REQ, updated at grant.
// - Min transfer: req@T -> gnt@T+1 -> ACCESS@T+2 -> done@T+3 (ready@T+2).
// - Back-to-back grants are separated by one IDLE cycle.
// - req_sel=0 at grant: no bus cycle. gnt@T+1, done@T+2 with rsp_err=1, rsp_rdata=0.
// - req deasserted before gnt: not served. req after gnt: treated as a new request.
// - Simultaneous reqs: only one gnt per arbitration; losers keep waiting.
// CONFIGURATION
// - APB_TIMEOUT_EN defined:
//   - 8-bit counter counts ACCESS cycles.
//   - If ready is still 0 after TIMEOUT_CYCLES ACCESS cycles, abort:
//     done=1, rsp_err=1, rsp_rdata=0, bus to idle.
//   - ready in the limit cycle itself = normal completion.
// - APB_TIMEOUT_EN undefined: ACCESS waits indefinitely. rsp_err only for sel=0.
// TESTING
// - Single write: req[0], sel=1, addr=8'h10, wdata=8'hA5, ready at 1st ACCESS ->
//   gnt@T+1, SETUP/ACCESS on bus, done[0]@T+3, err=0.
// - Read with 3 wait states: req[1], sel=2, apb_rdata=8'h3C, ready after 3 ACCESS cycles ->
//   enable high 4 cycles, done[1], rsp_rdata=8'h3C.
// - Round-robin: req=3'b111 held throughout, zero-wait slave ->
//   grant order 0,1,2,0; no requester starves.
// - Illegal sel: req[2], sel=0 -> apb_sel stays 0, done[2]@T+2, rsp_err=1.
// - Reset in ACCESS: assert reset one cycle ->
//   all outputs 0 next cycle, no done, next grant starts from requester 0.
// - APB_TIMEOUT_EN, TIMEOUT_CYCLES=4, ready never high ->
//   done after 4 ACCESS cycles, rsp_err=1, rsp_rdata=0.

Source files
------------

// File: rtl/apb_bus_arbiter.sv
// Round-robin APB master: N_REQ requesters share one APB bus, one SETUP/ACCESS transfer per grant.
// Optional ACCESS-phase timeout abort is compiled in when APB_TIMEOUT_EN is defined.
module apb_bus_arbiter #(
   parameter int unsigned N_REQ          = 3,
   parameter int unsigned AW             = 8,
   parameter int unsigned DW             = 8,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_REQ-1:0]      req,
   input  logic [N_REQ-1:0]      req_write,
   input  logic [2*N_REQ-1:0]    req_sel,
   input  logic [N_REQ*AW-1:0]   req_addr,
   input  logic [N_REQ*DW-1:0]   req_wdata,
   output logic [N_REQ-1:0]      gnt,
   output logic [N_REQ-1:0]      done,
   output logic [DW-1:0]         rsp_rdata,
   output logic                  rsp_err,
   output logic [1:0]            apb_sel,
   output logic                  apb_write,
   output logic                  apb_enable,
   output logic [AW-1:0]         apb_addr,
   output logic [DW-1:0]         apb_wdata,
   input  logic [DW-1:0]         apb_rdata,
   input  logic                  apb_ready
);

   localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_ERR} state_t;

   state_t           r_state, w_state;
   logic [PW-1:0]    r_rr_ptr, w_rr_ptr, r_owner, w_owner, w_win;
   logic             w_found;
   logic             w_cmd_write;
   logic [1:0]       w_cmd_sel;
   logic [AW-1:0]    w_cmd_addr;
   logic [DW-1:0]    w_cmd_wdata;
   logic [N_REQ-1:0] r_gnt, w_gnt, r_done, w_done;
   logic [DW-1:0]    r_rdata, w_rdata, r_wdata, w_wdata;
   logic             r_err, w_err, r_write, w_write, r_enable, w_enable;
   logic [1:0]       r_sel, w_sel;
   logic [AW-1:0]    r_addr, w_addr;
   logic             w_timeout;

   // Out-of-range configurations elaborate into an empty marker scope.
   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_config
   end

   function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int unsigned off);
      int unsigned sum;
      sum = 32'(base) + off;
      if (sum >= N_REQ) sum = sum - N_REQ;
      return PW'(sum);
   endfunction

   // Winner = first active request scanning upward from the round-robin pointer.
   always_comb begin
      w_found = 1'b0;
      w_win   = r_rr_ptr;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (!w_found && req[wrap_idx(r_rr_ptr, i)]) begin
            w_found = 1'b1;
            w_win   = wrap_idx(r_rr_ptr, i);
         end
      end
   end

   always_comb begin
      w_cmd_write = 1'b0;
      w_cmd_sel   = 2'd0;
      w_cmd_addr  = '0;
      w_cmd_wdata = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (PW'(i) == w_win) begin
            w_cmd_write = req_write[i];
            w_cmd_sel   = req_sel[2*i +: 2];
            w_cmd_addr  = req_addr[i*AW +: AW];
            w_cmd_wdata = req_wdata[i*DW +: DW];
         end
      end
   end

`ifdef APB_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] r_cnt, w_cnt;

   // Counter reads 0 in the first ACCESS cycle; the limit cycle is the last one allowed.
   always_comb w_cnt = (r_state == ST_ACCESS) ? r_cnt + 8'd1 : 8'd0;

   always_ff @(posedge clk) begin
      if (reset) r_cnt <= 8'd0;
      else       r_cnt <= w_cnt;
   end

   assign w_timeout = (r_cnt == TO_LAST);
`else
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_state  = r_state;
      w_rr_ptr = r_rr_ptr;
      w_owner  = r_owner;
      w_gnt    = '0;
      w_done   = '0;
      w_rdata  = '0;
      w_err    = 1'b0;
      w_sel    = r_sel;
      w_enable = r_enable;
      w_write  = r_write;
      w_addr   = r_addr;
      w_wdata  = r_wdata;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_owner        = w_win;
               w_rr_ptr       = wrap_idx(w_win, 1);
               w_gnt[w_win]   = 1'b1;
               w_write        = w_cmd_write;
               w_addr         = w_cmd_addr;
               w_wdata        = w_cmd_wdata;
               w_sel          = w_cmd_sel;
               w_enable       = 1'b0;
               w_state        = (w_cmd_sel == 2'd0) ? ST_ERR : ST_SETUP;
            end
         end
         ST_SETUP: begin
            w_enable = 1'b1;
            w_state  = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (apb_ready) begin
               w_done[r_owner] = 1'b1;
               w_rdata         = r_write ? '0 : apb_rdata;
               w_sel           = 2'd0;
               w_enable        = 1'b0;
               w_state         = ST_IDLE;
            end else if (w_timeout) begin
               w_done[r_owner] = 1'b1;
               w_err           = 1'b1;
               w_sel           = 2'd0;
               w_enable        = 1'b0;
               w_state         = ST_IDLE;
            end
         end
         ST_ERR: begin
            w_done[r_owner] = 1'b1;
            w_err           = 1'b1;
            w_state         = ST_IDLE;
         end
         default: w_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_rr_ptr <= '0;
         r_owner  <= '0;
         r_gnt    <= '0;
         r_done   <= '0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
         r_sel    <= 2'd0;
         r_enable <= 1'b0;
         r_write  <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
      end else begin
         r_state  <= w_state;
         r_rr_ptr <= w_rr_ptr;
         r_owner  <= w_owner;
         r_gnt    <= w_gnt;
         r_done   <= w_done;
         r_rdata  <= w_rdata;
         r_err    <= w_err;
         r_sel    <= w_sel;
         r_enable <= w_enable;
         r_write  <= w_write;
         r_addr   <= w_addr;
         r_wdata  <= w_wdata;
      end
   end

   assign gnt        = r_gnt;
   assign done       = r_done;
   assign rsp_rdata  = r_rdata;
   assign rsp_err    = r_err;
   assign apb_sel    = r_sel;
   assign apb_write  = r_write;
   assign apb_enable = r_enable;
   assign apb_addr   = r_addr;
   assign apb_wdata  = r_wdata;

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Directed bench for apb_bus_arbiter: write, wait-state read, illegal sel, round-robin,
// long/timeout ACCESS (APB_TIMEOUT_EN selects the timeout variant) and reset mid-transfer.
module tb_apb_bus_arbiter;
   localparam int unsigned N_REQ = 3;
   localparam int unsigned AW    = 8;
   localparam int unsigned DW    = 8;
   localparam int unsigned TO    = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [N_REQ-1:0]  req, req_write;
   logic [1:0]        sel_v  [N_REQ];
   logic [AW-1:0]     addr_v [N_REQ];
   logic [DW-1:0]     wdat_v [N_REQ];
   logic [2*N_REQ-1:0]  req_sel;
   logic [N_REQ*AW-1:0] req_addr;
   logic [N_REQ*DW-1:0] req_wdata;
   logic [N_REQ-1:0]  gnt, done;
   logic [DW-1:0]     rsp_rdata;
   logic              rsp_err;
   logic [1:0]        apb_sel;
   logic              apb_write, apb_enable;
   logic [AW-1:0]     apb_addr;
   logic [DW-1:0]     apb_wdata;
   logic [DW-1:0]     apb_rdata;
   logic              apb_ready;

   int n_chk  = 0;
   int n_pass = 0;
   int n_en;
   int n_done;

   assign req_sel   = {sel_v[2], sel_v[1], sel_v[0]};
   assign req_addr  = {addr_v[2], addr_v[1], addr_v[0]};
   assign req_wdata = {wdat_v[2], wdat_v[1], wdat_v[0]};

   always #5 clk = ~clk;

   apb_bus_arbiter #(
      .N_REQ(N_REQ), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(reset),
      .req(req), .req_write(req_write), .req_sel(req_sel),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .gnt(gnt), .done(done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .apb_sel(apb_sel), .apb_write(apb_write), .apb_enable(apb_enable),
      .apb_addr(apb_addr), .apb_wdata(apb_wdata),
      .apb_rdata(apb_rdata), .apb_ready(apb_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_bus(input string tag);
      chk({tag, "_sel"}, 32'(apb_sel), 32'h0);
      chk({tag, "_en"},  32'(apb_enable), 32'h0);
   endtask

   initial begin
      reset     = 1'b1;
      req       = '0;
      req_write = '0;
      apb_rdata = '0;
      apb_ready = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         sel_v[i]  = 2'd0;
         addr_v[i] = '0;
         wdat_v[i] = '0;
      end
      tick();
      tick();
      chk("rst_gnt",   32'(gnt), 32'h0);
      chk("rst_done",  32'(done), 32'h0);
      chk("rst_err",   32'(rsp_err), 32'h0);
      chk("rst_rdata", 32'(rsp_rdata), 32'h0);
      chk_idle_bus("rst");
      reset = 1'b0;

      // Single zero-wait write from requester 0
      req = 3'b001; req_write[0] = 1'b1; sel_v[0] = 2'd1; addr_v[0] = 8'h10; wdat_v[0] = 8'hA5;
      apb_ready = 1'b1;
      tick();
      chk("wr_gnt",   32'(gnt), 32'h1);
      chk("wr_sel",   32'(apb_sel), 32'h1);
      chk("wr_en0",   32'(apb_enable), 32'h0);
      chk("wr_addr",  32'(apb_addr), 32'h10);
      chk("wr_wdata", 32'(apb_wdata), 32'hA5);
      chk("wr_dir",   32'(apb_write), 32'h1);
      req = '0;
      tick();
      chk("wr_en1",   32'(apb_enable), 32'h1);
      chk("wr_sel_a", 32'(apb_sel), 32'h1);
      chk("wr_nodone", 32'(done), 32'h0);
      tick();
      chk("wr_done",  32'(done), 32'h1);
      chk("wr_err",   32'(rsp_err), 32'h0);
      chk("wr_rdata", 32'(rsp_rdata), 32'h0);
      chk_idle_bus("wr_end");

      // Read with three wait states from requester 1
      req = 3'b010; req_write[1] = 1'b0; sel_v[1] = 2'd2; addr_v[1] = 8'h22;
      apb_rdata = 8'h3C; apb_ready = 1'b0;
      tick();
      chk("rd_gnt", 32'(gnt), 32'h2);
      chk("rd_sel", 32'(apb_sel), 32'h2);
      chk("rd_dir", 32'(apb_write), 32'h0);
      req = '0;
      tick();
      chk("rd_en_a1", 32'(apb_enable), 32'h1);
      tick();
      chk("rd_en_a2", 32'(apb_enable), 32'h1);
      tick();
      chk("rd_en_a3", 32'(apb_enable), 32'h1);
      chk("rd_wait_nodone", 32'(done), 32'h0);
      tick();
      chk("rd_en_a4", 32'(apb_enable), 32'h1);
      apb_ready = 1'b1;
      tick();
      chk("rd_done",  32'(done), 32'h2);
      chk("rd_rdata", 32'(rsp_rdata), 32'h3C);
      chk("rd_err",   32'(rsp_err), 32'h0);
      chk_idle_bus("rd_end");

      // Illegal slave id from requester 2: no bus cycle, error completion
      req = 3'b100; req_write[2] = 1'b0; sel_v[2] = 2'd0;
      tick();
      chk("il_gnt", 32'(gnt), 32'h4);
      chk_idle_bus("il_g");
      req = '0;
      tick();
      chk("il_done",  32'(done), 32'h4);
      chk("il_err",   32'(rsp_err), 32'h1);
      chk("il_rdata", 32'(rsp_rdata), 32'h0);
      chk_idle_bus("il_d");

      // Round-robin with all three requesting, zero-wait slave: 0,1,2,0
      sel_v[0] = 2'd1; sel_v[1] = 2'd2; sel_v[2] = 2'd3;
      req_write = 3'b111;
      req = 3'b111;
      begin
         logic [N_REQ-1:0] exp_oh [4];
         logic [1:0]       exp_id [4];
         exp_oh[0] = 3'b001; exp_oh[1] = 3'b010; exp_oh[2] = 3'b100; exp_oh[3] = 3'b001;
         exp_id[0] = 2'd1;   exp_id[1] = 2'd2;   exp_id[2] = 2'd3;   exp_id[3] = 2'd1;
         for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rr%0d_gnt", k), 32'(gnt), 32'(exp_oh[k]));
            chk($sformatf("rr%0d_sel", k), 32'(apb_sel), 32'(exp_id[k]));
            tick();
            tick();
            chk($sformatf("rr%0d_done", k), 32'(done), 32'(exp_oh[k]));
            if (k == 3) req = '0;
         end
      end
      req_write = '0;

      // Long ACCESS phase on requester 1 (read, slave never ready at first)
      req = 3'b010; sel_v[1] = 2'd2; apb_rdata = 8'h5A; apb_ready = 1'b0;
      tick();
      chk("lg_gnt", 32'(gnt), 32'h2);
      req = '0;
      n_en = 0; n_done = 0;
`ifdef APB_TIMEOUT_EN
      for (int c = 0; c < TO; c++) begin
         tick();
         if (apb_enable) n_en++;
         if (done != '0) n_done++;
      end
      chk("to_en_cycles", 32'(n_en), 32'(TO));
      chk("to_no_early_done", 32'(n_done), 32'h0);
      tick();
      chk("to_done",  32'(done), 32'h2);
      chk("to_err",   32'(rsp_err), 32'h1);
      chk("to_rdata", 32'(rsp_rdata), 32'h0);
      chk_idle_bus("to_end");
`else
      for (int c = 0; c < 20; c++) begin
         tick();
         if (apb_enable) n_en++;
         if (done != '0) n_done++;
      end
      chk("lg_en_cycles", 32'(n_en), 32'd20);
      chk("lg_no_done", 32'(n_done), 32'h0);
      apb_ready = 1'b1;
      tick();
      chk("lg_done",  32'(done), 32'h2);
      chk("lg_err",   32'(rsp_err), 32'h0);
      chk("lg_rdata", 32'(rsp_rdata), 32'h5A);
      chk_idle_bus("lg_end");
`endif

      // Reset during ACCESS drops the transfer and restarts arbitration at requester 0
      req = 3'b010; addr_v[1] = 8'h22; wdat_v[1] = 8'h77; req_write[1] = 1'b1; apb_ready = 1'b0;
      tick();
      chk("rs_gnt", 32'(gnt), 32'h2);
      req = '0;
      tick();
      chk("rs_in_access", 32'(apb_enable), 32'h1);
      reset = 1'b1;
      tick();
      chk("rs_gnt0",   32'(gnt), 32'h0);
      chk("rs_done0",  32'(done), 32'h0);
      chk("rs_err0",   32'(rsp_err), 32'h0);
      chk("rs_rdata0", 32'(rsp_rdata), 32'h0);
      chk("rs_addr0",  32'(apb_addr), 32'h0);
      chk("rs_wdata0", 32'(apb_wdata), 32'h0);
      chk("rs_write0", 32'(apb_write), 32'h0);
      chk_idle_bus("rs");
      reset = 1'b0;
      req = 3'b111; req_write = '0; apb_ready = 1'b1; apb_rdata = 8'h81;
      tick();
      chk("rs_next_gnt",  32'(gnt), 32'h1);
      chk("rs_nodone",    32'(done), 32'h0);
      req = '0;
      tick();
      tick();
      chk("rs_next_done",  32'(done), 32'h1);
      chk("rs_next_rdata", 32'(rsp_rdata), 32'h81);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
